// File: rtl/frame_write_ctrl.sv
// Write-side sequencer for the 8-bit frame buffer.
// It runs one job at a time: either a full-screen clear to CLEAR_COLOR, or a
// sequential load of RGB888 pixels. Loaded pixels are packed to RGB332 and
// written from a base address, wrapping at the end of the frame.
// Every output is a flop. A write appears one cycle after the state that
// issues it.
module frame_write_ctrl #(
    parameter int          H_RES       = 640,
    parameter int          V_RES       = 480,
    parameter int          ADDR_W      = 19,
    parameter logic [7:0]  CLEAR_COLOR = 8'h00
) (
    input  logic              Clk,
    input  logic              Reset_h,
    input  logic              start_clear,
    input  logic              start_load,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              pix_valid,
    input  logic [23:0]       pix_data,
    output logic              pix_ready,
    output logic [7:0]        fb_data,
    output logic [ADDR_W-1:0] fb_wraddress,
    output logic              fb_wren,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // The frame size may equal 2^ADDR_W, so it needs one extra bit.
    localparam logic [ADDR_W:0]   FB_SIZE   = (ADDR_W+1)'(H_RES * V_RES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic              pix_ready_q, pix_ready_d;
    logic              fb_wren_q, fb_wren_d;
    logic [7:0]        fb_data_q, fb_data_d;
    logic [ADDR_W-1:0] fb_wraddress_q, fb_wraddress_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // These are helper terms shared by the next-state logic and the output logic.
    // The busy_q term keeps starts blocked during the visible done cycle. This
    // means a start is accepted exactly when the busy output is low.
    logic              start_ok;
    logic              take_clear;
    logic              take_load;
    logic              base_bad;
    logic              accept;
    logic [ADDR_W:0]   addr_plus;
    logic [ADDR_W-1:0] addr_wrap;
    logic [ADDR_W-1:0] rem_dec;
    logic [7:0]        pix332;

    assign start_ok   = (state_q == ST_IDLE) && !busy_q;
    assign take_clear = start_ok && start_clear;
    assign take_load  = start_ok && !start_clear && start_load;
    assign base_bad   = ({1'b0, load_base} >= FB_SIZE);
    assign accept     = (state_q == ST_LOAD) && pix_valid && pix_ready_q;
    assign addr_plus  = {1'b0, addr_q} + (ADDR_W+1)'(1);
    assign addr_wrap  = (addr_plus == FB_SIZE) ? '0 : addr_plus[ADDR_W-1:0];
    assign rem_dec    = rem_q - ADDR_W'(1);
    assign pix332     = {pix_data[23:21], pix_data[15:13], pix_data[7:6]};

    // This block holds the state register and all registered outputs and counters.
    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            rem_q          <= '0;
            pix_ready_q    <= 1'b0;
            fb_wren_q      <= 1'b0;
            fb_data_q      <= 8'h00;
            fb_wraddress_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            rem_q          <= rem_d;
            pix_ready_q    <= pix_ready_d;
            fb_wren_q      <= fb_wren_d;
            fb_data_q      <= fb_data_d;
            fb_wraddress_q <= fb_wraddress_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    // This block is the next-state logic. Clear wins over load, and an empty or
    // illegal load goes straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (take_clear) begin
                    state_d = ST_CLEAR;
                end else if (take_load) begin
                    if ((load_len == '0) || base_bad) state_d = ST_DONE;
                    else                              state_d = ST_LOAD;
                end
            end
            ST_CLEAR: begin
                if (addr_q == LAST_ADDR) state_d = ST_DONE;
            end
            ST_LOAD: begin
                if (accept && (rem_q == ADDR_W'(1))) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // This block is the output and datapath logic. It computes the write port,
    // the handshake, the status flags and the counters for the next cycle.
    always_comb begin
        addr_d         = addr_q;
        rem_d          = rem_q;
        pix_ready_d    = 1'b0;
        fb_wren_d      = 1'b0;
        fb_data_d      = fb_data_q;
        fb_wraddress_d = fb_wraddress_q;
        busy_d         = (state_d != ST_IDLE) || (state_q == ST_DONE);
        done_d         = (state_q == ST_DONE);
        err_d          = err_q;
        case (state_q)
            ST_IDLE: begin
                if (take_clear) begin
                    addr_d = '0;
                    err_d  = 1'b0;
                end else if (take_load) begin
                    addr_d      = load_base;
                    rem_d       = load_len;
                    err_d       = base_bad;
                    pix_ready_d = (state_d == ST_LOAD);
                end
            end
            ST_CLEAR: begin
                fb_wren_d      = 1'b1;
                fb_data_d      = CLEAR_COLOR;
                fb_wraddress_d = addr_q;
                addr_d         = addr_q + ADDR_W'(1);
            end
            ST_LOAD: begin
                if (accept) begin
                    fb_wren_d      = 1'b1;
                    fb_data_d      = pix332;
                    fb_wraddress_d = addr_q;
                    addr_d         = addr_wrap;
                    rem_d          = rem_dec;
                    pix_ready_d    = (rem_dec != '0);
                end else begin
                    pix_ready_d    = pix_ready_q;
                end
            end
            default: ;
        endcase
    end

    assign pix_ready    = pix_ready_q;
    assign fb_data      = fb_data_q;
    assign fb_wraddress = fb_wraddress_q;
    assign fb_wren      = fb_wren_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Directed bench for frame_write_ctrl.
// A small instance (4x2 frame, colour E3) is driven from a per-cycle vector
// table. A default-size instance covers a reset in the middle of a clear.
module tb_frame_write_ctrl;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    // This is the small instance, with FB_SIZE = 8 and a 4-bit address.
    logic        Reset_h;
    logic        start_clear, start_load, pix_valid;
    logic [3:0]  load_base, load_len;
    logic [23:0] pix_data;
    logic        pix_ready, fb_wren, busy, done, err;
    logic [7:0]  fb_data;
    logic [3:0]  fb_wraddress;

    frame_write_ctrl #(.H_RES(4), .V_RES(2), .ADDR_W(4), .CLEAR_COLOR(8'hE3)) dut (
        .Clk(Clk), .Reset_h(Reset_h),
        .start_clear(start_clear), .start_load(start_load),
        .load_base(load_base), .load_len(load_len),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .fb_data(fb_data), .fb_wraddress(fb_wraddress), .fb_wren(fb_wren),
        .busy(busy), .done(done), .err(err)
    );

    // This is the default-size instance, with a 640x480 frame.
    logic        b_rst, b_start_clear;
    logic        b_pix_ready, b_fb_wren, b_busy, b_done, b_err;
    logic [7:0]  b_fb_data;
    logic [18:0] b_fb_wraddress;

    frame_write_ctrl big (
        .Clk(Clk), .Reset_h(b_rst),
        .start_clear(b_start_clear), .start_load(1'b0),
        .load_base(19'd0), .load_len(19'd0),
        .pix_valid(1'b0), .pix_data(24'h0), .pix_ready(b_pix_ready),
        .fb_data(b_fb_data), .fb_wraddress(b_fb_wraddress), .fb_wren(b_fb_wren),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    typedef struct {
        logic        sc, sl;
        logic [3:0]  base, len;
        logic        pv;
        logic [23:0] pd;
        logic        rdy, wren;
        logic [7:0]  dat;
        logic [3:0]  adr;
        logic        bsy, dn, er;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic vec(input int sc, input int sl, input int base, input int len,
                       input int pv, input int pd, input int rdy, input int wren,
                       input int dat, input int adr, input int bsy, input int dn,
                       input int er);
        vec_t v;
        v.sc = sc[0]; v.sl = sl[0]; v.base = 4'(base); v.len = 4'(len);
        v.pv = pv[0]; v.pd = 24'(pd); v.rdy = rdy[0]; v.wren = wren[0];
        v.dat = 8'(dat); v.adr = 4'(adr); v.bsy = bsy[0]; v.dn = dn[0]; v.er = er[0];
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int row, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%0h exp=%0h", name, row, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset_h = 1'b1; b_rst = 1'b1; b_start_clear = 1'b0;
        start_clear = 1'b0; start_load = 1'b0; load_base = '0; load_len = '0;
        pix_valid = 1'b0; pix_data = '0;

        // ---------------- vector table (inputs, outputs after the edge) ----------------
        // Clear job. A start_load issued during the clear is ignored.
        vec(1,0,0,0,0,0,          0,0,0,0,   1,0,0);
        for (int i = 0; i < 8; i++)
            vec(0,(i==3)?1:0,5,2,0,0, 0,1,8'hE3,i, 1,0,0);
        vec(0,0,0,0,0,0,          0,0,0,0,   1,1,0);
        vec(0,0,0,0,0,0,          0,0,0,0,   0,0,0);
        // Basic load: base 2, three pixels.
        vec(0,1,2,3,0,0,          1,0,0,0,   1,0,0);
        vec(0,0,0,0,1,24'hFF0000, 1,1,8'hE0,2, 1,0,0);
        vec(0,0,0,0,1,24'h00FF00, 1,1,8'h1C,3, 1,0,0);
        vec(0,0,0,0,1,24'h0000FF, 0,1,8'h03,4, 1,0,0);
        vec(0,0,0,0,0,0,          0,0,0,0,   1,1,0);
        vec(0,0,0,0,0,0,          0,0,0,0,   0,0,0);
        // Wrap at the end of the frame: addresses 6,7,0,1.
        vec(0,1,6,4,0,0,          1,0,0,0,   1,0,0);
        vec(0,0,0,0,1,24'hFFFFFF, 1,1,8'hFF,6, 1,0,0);
        vec(0,0,0,0,1,24'hFFFFFF, 1,1,8'hFF,7, 1,0,0);
        vec(0,0,0,0,1,24'hFFFFFF, 1,1,8'hFF,0, 1,0,0);
        vec(0,0,0,0,1,24'hFFFFFF, 0,1,8'hFF,1, 1,0,0);
        vec(0,0,0,0,0,0,          0,0,0,0,   1,1,0);
        vec(0,0,0,0,0,0,          0,0,0,0,   0,0,0);
        // Stall: pix_valid goes 1,0,0,1 for a two-pixel load.
        vec(0,1,0,2,0,0,          1,0,0,0,   1,0,0);
        vec(0,0,0,0,1,24'h804020, 1,1,8'h88,0, 1,0,0);
        vec(0,0,0,0,0,24'h123456, 1,0,0,0,   1,0,0);
        vec(0,0,0,0,0,24'h123456, 1,0,0,0,   1,0,0);
        vec(0,0,0,0,1,24'h20C0C0, 0,1,8'h3B,1, 1,0,0);
        vec(0,0,0,0,0,0,          0,0,0,0,   1,1,0);
        vec(0,0,0,0,0,0,          0,0,0,0,   0,0,0);
        // Clear and load start together: only the clear runs, and pixels are never taken.
        vec(1,1,2,3,0,0,          0,0,0,0,   1,0,0);
        for (int i = 0; i < 8; i++)
            vec(0,0,0,0,1,24'hFFFFFF, 0,1,8'hE3,i, 1,0,0);
        vec(0,0,0,0,0,0,          0,0,0,0,   1,1,0);
        vec(0,0,0,0,0,0,          0,0,0,0,   0,0,0);
        // Illegal base 8: err is set and there are no writes.
        vec(0,1,8,3,1,24'hFFFFFF, 0,0,0,0,   1,0,1);
        vec(0,0,0,0,1,24'hFFFFFF, 0,0,0,0,   1,1,1);
        vec(0,0,0,0,0,0,          0,0,0,0,   0,0,1);
        // Zero length: done with no writes. The accepted start also clears err.
        vec(0,1,0,0,1,24'hFFFFFF, 0,0,0,0,   1,0,0);
        vec(0,0,0,0,1,24'hFFFFFF, 0,0,0,0,   1,1,0);
        vec(0,0,0,0,0,0,          0,0,0,0,   0,0,0);

        // ---------------- reset values ----------------
        repeat (2) @(posedge Clk);
        #1;
        check("rst_ready", -1, pix_ready, 0);
        check("rst_wren", -1, fb_wren, 0);
        check("rst_data", -1, fb_data, 0);
        check("rst_addr", -1, fb_wraddress, 0);
        check("rst_busy", -1, busy, 0);
        check("rst_done", -1, done, 0);
        check("rst_err", -1, err, 0);
        check("big_rst_busy", -1, b_busy, 0);
        Reset_h = 1'b0;

        // ---------------- apply the table ----------------
        foreach (vecs[i]) begin
            start_clear = vecs[i].sc; start_load = vecs[i].sl;
            load_base = vecs[i].base; load_len = vecs[i].len;
            pix_valid = vecs[i].pv; pix_data = vecs[i].pd;
            step();
            check("pix_ready", i, pix_ready, vecs[i].rdy);
            check("fb_wren", i, fb_wren, vecs[i].wren);
            if (vecs[i].wren) begin
                check("fb_data", i, fb_data, vecs[i].dat);
                check("fb_wraddress", i, fb_wraddress, vecs[i].adr);
            end
            check("busy", i, busy, vecs[i].bsy);
            check("done", i, done, vecs[i].dn);
            check("err", i, err, vecs[i].er);
            $display("row %0d sc=%0d sl=%0d pv=%0d -> rdy=%0d wren=%0d addr=%0d data=%02h busy=%0d done=%0d err=%0d",
                     i, vecs[i].sc, vecs[i].sl, vecs[i].pv, pix_ready, fb_wren,
                     fb_wraddress, fb_data, busy, done, err);
        end
        start_clear = 1'b0; start_load = 1'b0; pix_valid = 1'b0;

        // ---------------- reset in the middle of a full-size clear ----------------
        b_rst = 1'b0;
        step();
        b_start_clear = 1'b1;
        step();
        b_start_clear = 1'b0;
        check("big_start_busy", 0, b_busy, 1);
        repeat (1000) step();
        check("big_mid_wren", 1000, b_fb_wren, 1);
        check("big_mid_addr", 1000, b_fb_wraddress, 999);
        check("big_mid_data", 1000, b_fb_data, 0);
        $display("big clear cycle 1000 addr=%0d wren=%0d busy=%0d", b_fb_wraddress, b_fb_wren, b_busy);
        b_rst = 1'b1;
        step();
        b_rst = 1'b0;
        check("big_abort_wren", 0, b_fb_wren, 0);
        check("big_abort_busy", 0, b_busy, 0);
        check("big_abort_done", 0, b_done, 0);
        begin
            int activity = 0;
            for (int k = 0; k < 20; k++) begin
                step();
                if (b_done || b_fb_wren || b_busy) activity++;
            end
            check("big_quiet_after_abort", 0, activity, 0);
        end
        b_start_clear = 1'b1;
        step();
        b_start_clear = 1'b0;
        check("big_restart_busy", 0, b_busy, 1);
        step();
        check("big_restart_wren", 1, b_fb_wren, 1);
        check("big_restart_addr0", 1, b_fb_wraddress, 0);
        step();
        check("big_restart_addr1", 2, b_fb_wraddress, 1);
        $display("big restart addr=%0d wren=%0d", b_fb_wraddress, b_fb_wren);
        b_rst = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
